// File: rtl/cia_interrupt_ctrl.sv
// CIA interrupt control register: latches NSRC sources, masks them and drives /IRQ.
// Optional priority vector outputs (vec, vec_valid) when CIA_IRQ_VECTOR_EN is defined.
module cia_interrupt_ctrl #(
   parameter int              NSRC      = 5,
   parameter int              SRC_DELAY = 1,
   parameter logic [NSRC-1:0] SRC_EDGE  = '0,
   parameter logic [3:0]      ICR_ADDR  = 4'hD
) (
   input  logic            clk,
   input  logic            res_n,
   input  logic            phi2_up,
   input  logic            phi2_dn,
   input  logic            rd,
   input  logic            we,
   input  logic [3:0]      addr,
   input  logic [7:0]      data,
   input  logic [NSRC-1:0] sources,
   output logic [7:0]      regs,
   output logic            irq_n
`ifdef CIA_IRQ_VECTOR_EN
  ,output logic [((NSRC > 1) ? $clog2(NSRC) : 1)-1:0] vec,
   output logic            vec_valid
`endif
);

   localparam int VW = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic [NSRC-1:0] flags_q, flags_d, mask_q, mask_d, src_last_q;
   logic [NSRC-1:0] ev, ev_d, flags_next, pend;
   logic            ir_q, ir_d, rd_flags_q, rd_flags_d;
   logic            icr_sel;
   logic            unused_data;

   assign icr_sel     = (addr == ICR_ADDR);
   assign unused_data = ^data;

   // Edge-mode bits see only a rising transition since the previous phi2_up.
   assign ev = sources & ~(src_last_q & SRC_EDGE);

   generate
      if (SRC_DELAY == 0) begin : g_nodly
         assign ev_d = ev;
      end else begin : g_dly
         logic [NSRC-1:0] pipe_q [SRC_DELAY];
         for (genvar gi = 0; gi < SRC_DELAY; gi++) begin : g_stage
            if (gi == 0) begin : g_first
               always_ff @(posedge clk) begin
                  if (!res_n)       pipe_q[gi] <= '0;
                  else if (phi2_up) pipe_q[gi] <= ev;
               end
            end else begin : g_next
               always_ff @(posedge clk) begin
                  if (!res_n)       pipe_q[gi] <= '0;
                  else if (phi2_up) pipe_q[gi] <= pipe_q[gi-1];
               end
            end
         end
         assign ev_d = pipe_q[SRC_DELAY-1];
      end
   endgenerate

   // New events win over a coincident read clear.
   assign flags_next = ev_d | (flags_q & {NSRC{~rd_flags_q}});
   assign pend       = flags_next & mask_q;

   always_comb begin
      flags_d    = flags_q;
      mask_d     = mask_q;
      ir_d       = ir_q;
      rd_flags_d = rd_flags_q;
      if (phi2_up) begin
         flags_d    = flags_next;
         ir_d       = (|pend) | (ir_q & ~rd_flags_q);
         rd_flags_d = 1'b0;
      end
      if (phi2_dn) begin
         rd_flags_d = rd && icr_sel;
         if (we && icr_sel) begin
            if (data[7]) mask_d = mask_q | data[NSRC-1:0];
            else         mask_d = mask_q & ~data[NSRC-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!res_n) begin
         flags_q    <= '0;
         mask_q     <= '0;
         ir_q       <= 1'b0;
         rd_flags_q <= 1'b0;
         src_last_q <= '0;
      end else begin
         flags_q    <= flags_d;
         mask_q     <= mask_d;
         ir_q       <= ir_d;
         rd_flags_q <= rd_flags_d;
         if (phi2_up) src_last_q <= sources;
      end
   end

   always_comb begin
      regs            = 8'h00;
      regs[NSRC-1:0]  = flags_q;
      regs[7]         = ir_q;
   end

   assign irq_n = ~ir_q;

`ifdef CIA_IRQ_VECTOR_EN
   logic [VW-1:0] vec_q, vec_d;
   logic          vec_valid_q;

   // Descending scan so the lowest pending index is the last one written.
   always_comb begin
      vec_d = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pend[i]) vec_d = VW'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!res_n) begin
         vec_q       <= '0;
         vec_valid_q <= 1'b0;
      end else if (phi2_up) begin
         vec_q       <= vec_d;
         vec_valid_q <= |pend;
      end
   end

   assign vec       = vec_q;
   assign vec_valid = vec_valid_q;
`endif

endmodule

// File: tb/tb_cia_interrupt_ctrl.sv
// Directed bench for cia_interrupt_ctrl (NSRC=5, SRC_DELAY=1, source 2 edge-detected).
// Vector checks run only when CIA_IRQ_VECTOR_EN is defined.
module tb_cia_interrupt_ctrl;

   localparam int NSRC = 5;
   localparam logic [3:0] ICR = 4'hD;

   logic            clk = 1'b0;
   logic            res_n = 1'b0;
   logic            phi2_up = 1'b0, phi2_dn = 1'b0;
   logic            rd = 1'b0, we = 1'b0;
   logic [3:0]      addr = 4'h0;
   logic [7:0]      data = 8'h00;
   logic [NSRC-1:0] sources = '0;
   logic [7:0]      regs;
   logic            irq_n;
`ifdef CIA_IRQ_VECTOR_EN
   logic [2:0]      vec;
   logic            vec_valid;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cia_interrupt_ctrl #(
      .NSRC(NSRC), .SRC_DELAY(1), .SRC_EDGE(5'b00100), .ICR_ADDR(ICR)
   ) dut (
      .clk(clk), .res_n(res_n), .phi2_up(phi2_up), .phi2_dn(phi2_dn),
      .rd(rd), .we(we), .addr(addr), .data(data), .sources(sources),
      .regs(regs), .irq_n(irq_n)
`ifdef CIA_IRQ_VECTOR_EN
     ,.vec(vec), .vec_valid(vec_valid)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic up();
      phi2_up = 1'b1;
      @(negedge clk);
      phi2_up = 1'b0;
      @(negedge clk);
   endtask

   task automatic dn(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
      rd = r; we = w; addr = a; data = d;
      phi2_dn = 1'b1;
      @(negedge clk);
      phi2_dn = 1'b0; rd = 1'b0; we = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle_dn();
      dn(1'b0, 1'b0, 4'h0, 8'h00);
   endtask

   logic [7:0] edge_exp [4];

   initial begin
      edge_exp[0] = 8'h00; edge_exp[1] = 8'h05; edge_exp[2] = 8'h01; edge_exp[3] = 8'h01;
      repeat (3) @(negedge clk);
      check_eq("reset_regs", regs, 8'h00);
      check_eq("reset_irq", irq_n, 1'b1);
      res_n = 1'b1;
      @(negedge clk);

      // Enable source 0 and raise it
      dn(1'b0, 1'b1, ICR, 8'h81);
      sources = 5'h01; up();
      check_eq("en_latency", regs, 8'h00);
      sources = 5'h00; idle_dn(); up();
      check_eq("en_regs", regs, 8'h81);
      check_eq("en_irq", irq_n, 1'b0);

      // Read clear
      dn(1'b1, 1'b0, ICR, 8'h00);
      check_eq("rd_data", regs, 8'h81);
      up();
      check_eq("rdclr_regs", regs, 8'h00);
      check_eq("rdclr_irq", irq_n, 1'b1);

      // Reset mid-cycle with flag and mask set
      sources = 5'h01; up();
      sources = 5'h00; idle_dn(); up();
      check_eq("pre_rst_regs", regs, 8'h81);
      res_n = 1'b0; @(negedge clk); res_n = 1'b1;
      check_eq("rst_regs", regs, 8'h00);
      check_eq("rst_irq", irq_n, 1'b1);
      sources = 5'h01; up();
      sources = 5'h00; idle_dn(); up();
      check_eq("rst_mask_regs", regs, 8'h01);
      check_eq("rst_mask_irq", irq_n, 1'b1);
      dn(1'b1, 1'b0, ICR, 8'h00); up();
      check_eq("rst_clr_regs", regs, 8'h00);

      // Wrong address: neither write nor read clear apply
      dn(1'b0, 1'b1, 4'hC, 8'h9F);
      sources = 5'h02; up();
      sources = 5'h00; idle_dn(); up();
      check_eq("badaddr_wr_irq", irq_n, 1'b1);
      dn(1'b1, 1'b0, 4'hC, 8'h00); up();
      check_eq("badaddr_rd_regs", regs, 8'h02);
      repeat (10) @(negedge clk);
      check_eq("hold_regs", regs, 8'h02);
      dn(1'b1, 1'b0, ICR, 8'h00); up();
      check_eq("clr2_regs", regs, 8'h00);

      // Read race on source 1
      dn(1'b0, 1'b1, ICR, 8'h82);
      sources = 5'h02; up();
      sources = 5'h00; idle_dn(); up();
      check_eq("race_pre_regs", regs, 8'h82);
      sources = 5'h02; up();
      sources = 5'h00;
      dn(1'b1, 1'b0, ICR, 8'h00);
      check_eq("race_mid_irq", irq_n, 1'b0);
      up();
      check_eq("race_regs", regs, 8'h82);
      check_eq("race_irq", irq_n, 1'b0);
      dn(1'b1, 1'b0, ICR, 8'h00); up();
      check_eq("race_clr_regs", regs, 8'h00);
      check_eq("race_clr_irq", irq_n, 1'b1);

      // Edge source 2 vs level source 0 held high, read every cycle
      sources = 5'h05;
      for (int k = 0; k < 4; k++) begin
         up();
         check_eq($sformatf("edge_cyc%0d", k), regs, {24'h0, edge_exp[k]});
         dn(1'b1, 1'b0, ICR, 8'h00);
      end
      sources = 5'h00; up();
      dn(1'b1, 1'b0, ICR, 8'h00); up();
      check_eq("edge_clr_regs", regs, 8'h00);

`ifdef CIA_IRQ_VECTOR_EN
      dn(1'b0, 1'b1, ICR, 8'h9F);
      sources = 5'h0A; up();
      sources = 5'h00; idle_dn(); up();
      check_eq("vec_a", vec, 3'd1);
      check_eq("vec_valid", vec_valid, 1'b1);
      dn(1'b0, 1'b1, ICR, 8'h02); up();
      check_eq("vec_b", vec, 3'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
